// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//   Bundles the fetch unit's instruction-memory bus, datapath handshake and
//   redirect/fault signals.
//   master : the fetch unit (drives mem_addr/mem_rd and the instruction side)
//   slave  : the environment (memory + datapath + branch unit)
// Signals
//   mem_addr/mem_rd/mem_rdata          byte-wide instruction memory, 1-cycle read
//   instr/pc/pc_plus4/instr_valid      fetched instruction presented to datapath
//   instr_ready                        datapath accept
//   redirect/redirect_pc               branch/jump restart
//   fault                              misaligned-redirect fault (optional)
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_rdata;
  logic [31:0]       instr;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              fault;

  modport master (
    output mem_addr, mem_rd, instr, pc, pc_plus4, instr_valid, fault,
    input  mem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_rd, instr, pc, pc_plus4, instr_valid, fault,
    output mem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: holds the PC, reads one 32-bit big-endian instruction as four
//   byte reads from a byte-wide memory (data one cycle after the strobe), and
//   presents instr/pc/pc_plus4 over a valid/ready handshake. Redirects restart
//   fetch at a new target and discard any partial assembly.
// Ports
//   clk   clock, rising edge
//   rst   synchronous reset, active-low
//   bus   instr_fetch_unit_if.master (memory bus, handshake, redirect, fault)
// Build option
//   FETCH_ALIGN_CHECK_EN : when defined, a misaligned redirect enters a sticky
//   FAULT state (only reset leaves it). When undefined, redirect_pc[1:0] is
//   forced to zero and fault is tied low.
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FAULT} state_e;
`else
  typedef enum logic [1:0] {S_FETCH, S_HOLD} state_e;
`endif

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_rd_q, mem_rd_d;
  logic              rd_pend_q, rd_pend_d;   // a byte requested last cycle is on mem_rdata now
  logic [2:0]        req_cnt_q, req_cnt_d;   // reads issued for this word (0..4)
  logic [1:0]        cap_cnt_q, cap_cnt_d;   // bytes captured for this word (0..3)
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic [31:0]       pc_inc;
  logic [31:0]       redir_pc;

  assign pc_inc   = pc_q + 32'd4;
  assign redir_pc = {bus.redirect_pc[31:2], 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = 1'b0;
    rd_pend_d  = 1'b0;
    req_cnt_d  = req_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    valid_d    = valid_q;
    fault_d    = fault_q;

    unique case (state_q)
      S_FETCH: begin
        // Capture side: shift bytes in MSB-first so byte at pc lands in [31:24].
        rd_pend_d = mem_rd_q;
        if (rd_pend_q) begin
          instr_d   = {instr_q[23:0], bus.mem_rdata};
          cap_cnt_d = cap_cnt_q + 2'd1;
          if (cap_cnt_q == 2'd3) begin
            state_d = S_HOLD;
            valid_d = 1'b1;
          end
        end
        // Issue side: mem_rd/mem_addr are registered, so they are set one edge ahead.
        if (req_cnt_q < 3'd4) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = pc_q[ADDR_W-1:0] + ADDR_W'(req_cnt_q);
          req_cnt_d  = req_cnt_q + 3'd1;
        end
      end
      S_HOLD: begin
        if (valid_q && bus.instr_ready) begin
          // Start the next word immediately so throughput is one per 6 cycles.
          pc_d       = pc_inc;
          state_d    = S_FETCH;
          valid_d    = 1'b0;
          mem_rd_d   = 1'b1;
          mem_addr_d = pc_inc[ADDR_W-1:0];
          req_cnt_d  = 3'd1;
          cap_cnt_d  = 2'd0;
        end
      end
      default: begin
        // FAULT: frozen until reset.
      end
    endcase

    // Redirect wins over the handshake; a coincident valid&ready still counts as
    // consumed, it simply does not advance pc by 4.
`ifdef FETCH_ALIGN_CHECK_EN
    if (bus.redirect && state_q != S_FAULT) begin
      if (bus.redirect_pc[1:0] != 2'b00) begin
        state_d   = S_FAULT;
        fault_d   = 1'b1;
        valid_d   = 1'b0;
        mem_rd_d  = 1'b0;
        rd_pend_d = 1'b0;
      end else begin
        pc_d       = redir_pc;
        state_d    = S_FETCH;
        valid_d    = 1'b0;
        mem_rd_d   = 1'b1;
        mem_addr_d = redir_pc[ADDR_W-1:0];
        req_cnt_d  = 3'd1;
        cap_cnt_d  = 2'd0;
        rd_pend_d  = 1'b0;
      end
    end
`else
    if (bus.redirect) begin
      pc_d       = redir_pc;
      state_d    = S_FETCH;
      valid_d    = 1'b0;
      mem_rd_d   = 1'b1;
      mem_addr_d = redir_pc[ADDR_W-1:0];
      req_cnt_d  = 3'd1;
      cap_cnt_d  = 2'd0;
      rd_pend_d  = 1'b0;  // bytes in flight from the old fetch are dropped
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= 32'h0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      req_cnt_q  <= 3'd0;
      cap_cnt_q  <= 2'd0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      rd_pend_q  <= rd_pend_d;
      req_cnt_q  <= req_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.instr       = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_inc;
  assign bus.instr_valid = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign bus.fault       = fault_q;
`else
  assign bus.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [256];

  instr_fetch_unit_if #(.ADDR_W(8)) bus ();

  instr_fetch_unit #(.ADDR_W(8), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Byte memory: data one cycle after the strobe.
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [7:0] i0, i1, i2, i3;
    logic [31:0] t;
    t = a;          i0 = t[7:0];
    t = a + 32'd1;  i1 = t[7:0];
    t = a + 32'd2;  i2 = t[7:0];
    t = a + 32'd3;  i3 = t[7:0];
    return {mem[i0], mem[i1], mem[i2], mem[i3]};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Leaves the bench sampling cycle C0 of the first fetch.
  task automatic do_reset();
    bus.redirect = 1'b0; bus.instr_ready = 1'b0;
    rst = 1'b0; tick(); tick();
    rst = 1'b1; tick();
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus.instr_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; tick(); tick();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 8'h0 ||
        bus.pc !== 32'h0 || bus.instr !== 32'h0 || bus.fault !== 1'b0 || bus.pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL reset: valid=%b rd=%b addr=%h pc=%h instr=%h fault=%b p4=%h expected 0/0/0/0/0/0/4",
               bus.instr_valid, bus.mem_rd, bus.mem_addr, bus.pc, bus.instr, bus.fault, bus.pc_plus4);
    end
  endtask

  task automatic test_basic();
    rst = 1'b1; tick();  // C0
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'(k) || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_issue C%0d: rd=%b addr=%h valid=%b expected 1/%h/0", k, bus.mem_rd, bus.mem_addr, bus.instr_valid, k);
      end
      tick();
    end
    checks++;  // C4
    if (bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL basic_c4: rd=%b valid=%b expected 0/0", bus.mem_rd, bus.instr_valid);
    end
    tick();    // C5
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr !== 32'h20080005 || bus.pc !== 32'h0 || bus.pc_plus4 !== 32'h4) begin
      errors++;
      $display("FAIL basic_c5: valid=%b instr=%h pc=%h p4=%h expected 1/20080005/0/4", bus.instr_valid, bus.instr, bus.pc, bus.pc_plus4);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.mem_rd !== 1'b0 || bus.instr !== 32'h20080005 || bus.pc !== 32'h0) begin
        errors++;
        $display("FAIL stall%0d: valid=%b rd=%b instr=%h pc=%h expected 1/0/20080005/0", i, bus.instr_valid, bus.mem_rd, bus.instr, bus.pc);
      end
    end
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h04 || bus.instr_valid !== 1'b0 || bus.pc !== 32'h4) begin
      errors++;
      $display("FAIL stall_release: rd=%b addr=%h valid=%b pc=%h expected 1/04/0/4", bus.mem_rd, bus.mem_addr, bus.instr_valid, bus.pc);
    end
  endtask

  task automatic test_redirect_mid();
    bit ok;
    do_reset(); tick(); tick();  // C2
    bus.redirect = 1'b1; bus.redirect_pc = 32'h40; tick(); bus.redirect = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bus.instr_valid !== 1'b0 || (k < 4 && (bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'(8'h40 + k)))) begin
        errors++;
        $display("FAIL redir_mid C%0d: valid=%b rd=%b addr=%h expected 0/1/%h", k, bus.instr_valid, bus.mem_rd, bus.mem_addr, 8'h40 + k);
      end
      tick();
    end
    wait_valid(1, ok);
    checks++;
    if (!ok || bus.pc !== 32'h40 || bus.instr !== word_at(32'h40)) begin
      errors++;
      $display("FAIL redir_mid_valid: ok=%b pc=%h instr=%h expected 1/40/%h", ok, bus.pc, bus.instr, word_at(32'h40));
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFC; tick(); bus.redirect = 1'b0;
    wait_valid(10, ok);
    checks++;
    if (!ok || bus.pc !== 32'hFC || bus.pc_plus4 !== 32'h100 || bus.instr !== word_at(32'hFC)) begin
      errors++;
      $display("FAIL wrap_word: ok=%b pc=%h p4=%h instr=%h expected 1/fc/100/%h", ok, bus.pc, bus.pc_plus4, bus.instr, word_at(32'hFC));
    end
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0;
    checks++;
    if (bus.mem_addr !== 8'h00 || bus.mem_rd !== 1'b1 || bus.pc !== 32'h100) begin
      errors++;
      $display("FAIL wrap_next: addr=%h rd=%b pc=%h expected 00/1/100", bus.mem_addr, bus.mem_rd, bus.pc);
    end
    wait_valid(10, ok);
    checks++;
    if (!ok || bus.pc !== 32'h100 || bus.instr !== word_at(32'h100)) begin
      errors++;
      $display("FAIL wrap_second: ok=%b pc=%h instr=%h expected 1/100/%h", ok, bus.pc, bus.instr, word_at(32'h100));
    end
  endtask

  task automatic test_redirect_handshake();
    bit ok;
    do_reset();
    wait_valid(10, ok);
    bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h80; tick();
    bus.instr_ready = 1'b0; bus.redirect = 1'b0;
    checks++;
    if (!ok || bus.pc !== 32'h80 || bus.mem_addr !== 8'h80 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_hs: ok=%b pc=%h addr=%h valid=%b expected 1/80/80/0", ok, bus.pc, bus.mem_addr, bus.instr_valid);
    end
    wait_valid(10, ok);
    checks++;
    if (!ok || bus.pc !== 32'h80 || bus.instr !== word_at(32'h80)) begin
      errors++;
      $display("FAIL redir_hs_word: ok=%b pc=%h instr=%h expected 1/80/%h", ok, bus.pc, bus.instr, word_at(32'h80));
    end
  endtask

  task automatic test_misaligned();
    bit ok;
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h42; tick(); bus.redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    checks++;
    if (bus.fault !== 1'b1 || bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL misalign_fault: fault=%b rd=%b valid=%b expected 1/0/0", bus.fault, bus.mem_rd, bus.instr_valid);
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h80; tick(); bus.redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.fault !== 1'b1 || bus.mem_rd !== 1'b0 || bus.instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL misalign_sticky%0d: fault=%b rd=%b valid=%b expected 1/0/0", i, bus.fault, bus.mem_rd, bus.instr_valid);
      end
      tick();
    end
`else
    checks++;
    if (bus.fault !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 8'h40 || bus.pc !== 32'h40) begin
      errors++;
      $display("FAIL misalign_align: fault=%b rd=%b addr=%h pc=%h expected 0/1/40/40", bus.fault, bus.mem_rd, bus.mem_addr, bus.pc);
    end
    wait_valid(10, ok);
    checks++;
    if (!ok || bus.pc !== 32'h40 || bus.instr !== word_at(32'h40) || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL misalign_word: ok=%b pc=%h instr=%h fault=%b expected 1/40/%h/0", ok, bus.pc, bus.instr, bus.fault, word_at(32'h40));
    end
`endif
  endtask

  task automatic test_reset_midfetch();
    do_reset();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h20; tick(); bus.redirect = 1'b0;  // C0 at 0x20
    tick(); tick(); tick();  // C3
    rst = 1'b0; tick();
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 8'h0 ||
        bus.pc !== 32'h0 || bus.instr !== 32'h0 || bus.fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b rd=%b addr=%h pc=%h instr=%h fault=%b expected all 0",
               bus.instr_valid, bus.mem_rd, bus.mem_addr, bus.pc, bus.instr, bus.fault);
    end
    rst = 1'b1;
  endtask

  // Random ready/redirect traffic against a transaction-level model: valid is
  // due 6 cycles after each fetch start, and each presented word is the memory
  // word at the model's pc.
  task automatic test_random();
    logic [31:0] exp_pc, tgt;
    int          age;
    bit          rdy, red, ev;
    do_reset();
    exp_pc = 32'h0; age = 1;
    for (int n = 0; n < 3000; n++) begin
      checks++;
      if (bus.instr_valid !== (age >= 6)) begin
        errors++;
        $display("FAIL rand_valid n=%0d: valid=%b expected %b", n, bus.instr_valid, age >= 6);
      end
      if (bus.instr_valid) begin
        checks++;
        if (bus.pc !== exp_pc || bus.pc_plus4 !== exp_pc + 32'd4 || bus.instr !== word_at(exp_pc)) begin
          errors++;
          $display("FAIL rand_word n=%0d: pc=%h instr=%h expected %h/%h", n, bus.pc, bus.instr, exp_pc, word_at(exp_pc));
        end
      end
      rdy = ($urandom % 2) == 0;
      red = ($urandom % 12) == 0;
      tgt = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
      tgt[1:0] = 2'b00;
`endif
      bus.instr_ready = rdy; bus.redirect = red; bus.redirect_pc = tgt;
      ev = red || (bus.instr_valid && rdy);
      if (red) exp_pc = {tgt[31:2], 2'b00};
      else if (bus.instr_valid && rdy) exp_pc = exp_pc + 32'd4;
      tick();
      age = ev ? 1 : age + 1;
    end
    bus.instr_ready = 1'b0; bus.redirect = 1'b0;
  endtask

  initial begin
    bus.instr_ready = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_mid();
    test_wrap();
    test_redirect_handshake();
    test_misaligned();
    test_reset_midfetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
